// File: rtl/sub_resp_misr_if.sv
// sub_resp_misr_if: handshake and status bundle for the response MISR.
//   master side (fault-sim bench) drives: start, exp_sig, resp_valid, resp
//   slave side (sub_resp_misr) drives:    resp_ready, busy, done, pass,
//                                         signature, pat_cnt
interface sub_resp_misr_if #(
    parameter int WIDTH = 2,
    parameter int SIG_W = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [SIG_W-1:0] exp_sig;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output start, exp_sig, resp_valid, resp,
        input  resp_ready, busy, done, pass, signature, pat_cnt
    );

    modport slave (
        input  start, exp_sig, resp_valid, resp,
        output resp_ready, busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/sub_resp_misr.sv
// sub_resp_misr: compacts the per-pattern {s, c} responses of the subtractor
// cell into a multiple-input signature register, then compares the final
// signature against a golden value captured at start.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - sub_resp_misr_if.slave:
//            start, exp_sig       run control and golden signature
//            resp_valid, resp     response beats (accepted when resp_ready)
//            resp_ready, busy     high while a run is collecting beats
//            done, pass           run finished / signature matched golden
//            signature, pat_cnt   live MISR contents and accepted-beat count
module sub_resp_misr #(
    parameter int               WIDTH = 2,
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = 8'h1D,
    parameter logic [SIG_W-1:0] SEED  = 8'hFF,
    parameter int               NPAT  = 4,
    parameter int               CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sub_resp_misr_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SIG_W-1:0] exp_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             accept;
    logic             last_beat;

    // One MISR clock: shift left, fold the dropped MSB back through the
    // feedback taps, and inject the zero-extended response.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [WIDTH-1:0] r
    );
        logic [SIG_W-1:0] fb;
        fb = sig[SIG_W-1] ? POLY : '0;
        return {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-WIDTH){1'b0}}, r};
    endfunction

    always_comb begin
        accept    = busy_q && bus.resp_valid;
        sig_d     = misr_step(sig_q, bus.resp);
        cnt_d     = cnt_q + 1'b1;
        last_beat = (cnt_d == CNT_W'(NPAT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A beat presented alongside start is dropped: busy is
                    // still low in this cycle.
                    if (bus.start) begin
                        state_q <= S_RUN;
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        exp_q   <= bus.exp_sig;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        sig_q <= sig_d;
                        cnt_q <= cnt_d;
                        // The final beat's update and the verdict land on
                        // the same edge, so pass reflects the post-update value.
                        if (last_beat) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_d == exp_q);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resp_ready = busy_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.signature  = sig_q;
    assign bus.pat_cnt    = cnt_q;

endmodule
